requant_descaler: RTL and testbench
===================================

REQUANT_DESCALER -- requirements
Module: requant_descaler

Interface
REQ-001 Parameter FIFO_DEPTH, default 8: output FIFO entries, power of two, >=4.
REQ-002 Parameter SAMPLE_W, default 24: output sample width.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 x_in  input  16  signed 2's-complement mantissa from requantizer.
REQ-006 x_base_in  input  10  unsigned exponent in quarter-octaves (value = x_in * 2^(-x_base_in/4)).
REQ-007 din_v  input  1  x_in/x_base_in valid; no backpressure upstream.
REQ-008 granule_start  input  1  pulse; the next accepted sample gets index 0.
REQ-009 dout_ready  input  1  downstream ready.
REQ-010 sample_out  output  SAMPLE_W  signed descaled sample, Q8.15.
REQ-011 sample_idx  output  10  granule position 0..575 of sample_out.
REQ-012 last  output  1  high with the sample whose sample_idx = 575.
REQ-013 dout_v  output  1  sample_out/sample_idx/last valid.
REQ-014 overflow  output  1  sticky: a sample was dropped because the FIFO was full.

Function
REQ-015 Stage 1 SHALL register x_in, the shift s = x_base_in[9:2], the coefficient C[x_base_in[1:0]] = {32768, 27554, 23170, 19484} (Q1.15 of 2^(-k/4)) and the index.
REQ-016 Stage 2 SHALL register the 32-bit signed product p = x_in * C.
REQ-017 Stage 3 SHALL compute p >>> s with floor rounding; s >= 32 gives 0 for either sign.
REQ-018 Stage 3 SHALL saturate the result to [-2^23, 2^23-1] before the FIFO write.
REQ-019 Index counter: increments per din_v; wraps 575 -> 0; the index travels with its sample.
REQ-020 granule_start with din_v in the same cycle: that sample gets index 0. granule_start alone: the next din_v gets index 0.
REQ-021 FIFO is first-word-fall-through. dout_v = not empty. A pop occurs on dout_v && dout_ready.
REQ-022 Latency: a sample accepted at edge N appears on the outputs after edge N+3 when the FIFO is empty.
REQ-023 Full FIFO with a stage-3 write: if a pop occurs in the same cycle, the write is accepted; otherwise the sample is dropped and overflow is set.
REQ-024 Only granule_start or reset clears overflow. A granule_start and a drop in the same cycle leave overflow set.
REQ-025 Outputs SHALL hold stable while dout_v && !dout_ready.
REQ-026 Back-to-back din_v at one per cycle SHALL be sustained with no bubbles while dout_ready = 1.

Reset
REQ-027 rst_n low SHALL asynchronously clear pipeline valids, the index counter, FIFO pointers and overflow.
REQ-028 Outputs during reset: dout_v=0, sample_out=0, sample_idx=0, last=0, overflow=0.
REQ-029 Samples in flight when reset asserts mid-operation are discarded.
REQ-030 Reset release SHALL be synchronised internally; the first din_v is accepted on the second edge after release.

Structure
REQ-031 Shared package requant_pkg SHALL hold the coefficient table, GRANULE_LEN=576 and SAMPLE_W.
REQ-032 The FIFO SHALL be one sub-module, sync_fifo_fwft, parameterised by width and depth.
REQ-033 The datapath and index counter SHALL stay in requant_descaler.

Verification
REQ-034 x_in=100, x_base_in=28 -> sample_out=25600 three cycles later.
REQ-035 x_in=-100, x_base_in=29 -> sample_out=-21527 (floor rounding).
REQ-036 Saturation and large shift:
- x_in=1000, x_base_in=0 -> sample_out=8388607.
- x_in=-1000, x_base_in=0 -> sample_out=-8388608.
- x_in=5, x_base_in=200 -> sample_out=0.
REQ-037 granule_start, then 577 consecutive samples -> sample_idx 0..575 with last only at 575, then index 0.
REQ-038 dout_ready=0 for 20 samples with FIFO_DEPTH=8 -> 8 stored, overflow=1. Re-assert ready -> those 8 drain in order. Next granule_start -> overflow=0.
REQ-039 Assert rst_n low mid-stream -> dout_v=0 immediately. After release, no stale samples appear and the index restarts at 0.

Source files
------------

// File: rtl/requant_pkg.sv
// requant_pkg
//   Constants shared by the requantizer descaler and its testbench:
//   granule length, index and sample widths, and the Q1.15 table of
//   2^(-k/4) used to apply the fractional quarter-octave part of the
//   exponent.
package requant_pkg;

   localparam int GRANULE_LEN = 576;
   localparam int IDX_W       = 10;
   localparam int SAMPLE_W    = 24;
   localparam int MANT_W      = 16;
   localparam int BASE_W      = 10;
   localparam int SHIFT_W     = 8;
   localparam int COEF_W      = 16;
   localparam int PROD_W      = 32;

   // Q1.15 of 2^(-k/4), k = 0..3. Entry [0] is exactly 1.0 (32768), so the
   // coefficient is unsigned and needs the full 16 bits.
   localparam logic [3:0][COEF_W-1:0] COEF_TABLE = {
      16'd19484, 16'd23170, 16'd27554, 16'd32768
   };

   function automatic logic [COEF_W-1:0] coef_lookup(input logic [1:0] k);
      return COEF_TABLE[k];
   endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft
//   Single-clock first-word-fall-through FIFO. The head entry is presented
//   on rd_data whenever empty is low; rd_en pops it.
//   A write into a full FIFO is still accepted when a pop happens in the
//   same cycle (the freed slot is the one being written).
// Ports:
//   clk, rst_n      clock, async active-low reset (clears pointers only)
//   wr_en, wr_data  write request and data
//   rd_en           pop request (ignored while empty)
//   rd_data         head entry (undefined while empty)
//   full, empty     status flags
module sync_fifo_fwft #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   // Pointers carry one extra wrap bit to tell full from empty.
   logic [AW:0]      wptr_q, wptr_d;
   logic [AW:0]      rptr_q, rptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_rd;
   logic             do_wr;

   always_comb begin
      empty  = (wptr_q == rptr_q);
      full   = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
      do_rd  = rd_en && !empty;
      do_wr  = wr_en && (!full || do_rd);
      wptr_d = do_wr ? wptr_q + 1'b1 : wptr_q;
      rptr_d = do_rd ? rptr_q + 1'b1 : rptr_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   // Storage is not reset; empty masks its contents.
   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem_q[wptr_q[AW-1:0]] <= wr_data;
      end
   end

   assign rd_data = mem_q[rptr_q[AW-1:0]];

endmodule

// File: rtl/requant_descaler.sv
// requant_descaler
//   Turns requantizer output (mantissa x_in, exponent x_base_in in
//   quarter-octaves) into a linear Q8.15 sample:
//     sample = sat24( floor( x_in * C[base%4] / 2^(base/4) ) )
//   Three register stages (operand/coef, product, shift+saturate) feed an
//   output FIFO. Each sample carries its position within the 576-sample
//   granule.
// Ports:
//   clk, rst_n               clock, async active-low reset
//   x_in, x_base_in, din_v   input sample; accepted every cycle din_v is high
//   granule_start            restarts the granule index at 0
//   sample_out, sample_idx,
//   last, dout_v, dout_ready output stream (valid/ready)
//   overflow                 sticky: a sample was lost at a full FIFO
module requant_descaler
   import requant_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int SAMPLE_W   = requant_pkg::SAMPLE_W
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic signed [MANT_W-1:0]   x_in,
   input  logic        [BASE_W-1:0]   x_base_in,
   input  logic                       din_v,
   input  logic                       granule_start,
   input  logic                       dout_ready,
   output logic signed [SAMPLE_W-1:0] sample_out,
   output logic        [IDX_W-1:0]    sample_idx,
   output logic                       last,
   output logic                       dout_v,
   output logic                       overflow
);

   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(GRANULE_LEN - 1);
   localparam int               SAT_MAX_I = (1 << (SAMPLE_W - 1)) - 1;
   localparam int               SAT_MIN_I = -(1 << (SAMPLE_W - 1));
   localparam int               FIFO_W    = SAMPLE_W + IDX_W;

   // Release of rst_n is retimed through run_q; nothing is accepted until
   // run_q is high, i.e. from the second rising edge after release.
   logic run_q, run_d;

   logic               accept;
   logic               gs;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [IDX_W-1:0]   idx_assign;

   logic                      s1_v_q, s1_v_d;
   logic signed [MANT_W-1:0]  s1_x_q, s1_x_d;
   logic [SHIFT_W-1:0]        s1_s_q, s1_s_d;
   logic [COEF_W-1:0]         s1_c_q, s1_c_d;
   logic [IDX_W-1:0]          s1_idx_q, s1_idx_d;

   logic                      s2_v_q, s2_v_d;
   logic signed [PROD_W-1:0]  s2_p_q, s2_p_d;
   logic [SHIFT_W-1:0]        s2_s_q, s2_s_d;
   logic [IDX_W-1:0]          s2_idx_q, s2_idx_d;

   logic                      s3_v_q, s3_v_d;
   logic [SAMPLE_W-1:0]       s3_val_q, s3_val_d;
   logic [IDX_W-1:0]          s3_idx_q, s3_idx_d;

   logic                      overflow_q, overflow_d;

   logic signed [PROD_W-1:0]  shifted;
   logic signed [PROD_W-1:0]  clamped;

   logic [FIFO_W-1:0]         fifo_rd_data;
   logic                      fifo_full;
   logic                      fifo_empty;
   logic                      pop;
   logic                      drop;

   // Input acceptance and granule index. A granule_start in the same cycle
   // as din_v gives that sample index 0.
   always_comb begin
      run_d      = 1'b1;
      accept     = din_v && run_q;
      gs         = granule_start && run_q;
      idx_assign = gs ? '0 : idx_q;
      idx_d      = idx_q;
      if (accept) begin
         idx_d = (idx_assign == LAST_IDX) ? '0 : idx_assign + IDX_W'(1);
      end else if (gs) begin
         idx_d = '0;
      end
   end

   // Stage 1: operands, integer shift and fractional coefficient.
   always_comb begin
      s1_v_d   = accept;
      s1_x_d   = x_in;
      s1_s_d   = x_base_in[BASE_W-1:2];
      s1_c_d   = coef_lookup(x_base_in[1:0]);
      s1_idx_d = idx_assign;
   end

   // Stage 2: signed product; the coefficient is zero-extended so 32768
   // stays positive. |x * C| <= 2^30 fits the 32-bit product.
   always_comb begin
      s2_v_d   = s1_v_q;
      s2_p_d   = $signed({{(PROD_W-MANT_W){s1_x_q[MANT_W-1]}}, s1_x_q})
               * $signed({{(PROD_W-COEF_W){1'b0}}, s1_c_q});
      s2_s_d   = s1_s_q;
      s2_idx_d = s1_idx_q;
   end

   // Stage 3: arithmetic shift (floor), forced to 0 for shifts of 32 or
   // more regardless of sign, then saturation to the sample range.
   always_comb begin
      shifted = s2_p_q >>> s2_s_q[4:0];
      if (s2_s_q[SHIFT_W-1:5] != '0) begin
         shifted = '0;
      end
      clamped = shifted;
      if (shifted > SAT_MAX_I) begin
         clamped = SAT_MAX_I;
      end else if (shifted < SAT_MIN_I) begin
         clamped = SAT_MIN_I;
      end
      s3_v_d   = s2_v_q;
      s3_val_d = clamped[SAMPLE_W-1:0];
      s3_idx_d = s2_idx_q;
   end

   // Output handshake: a sample transfers on every rising edge where
   // dout_v && dout_ready; while dout_v is high and dout_ready low the
   // outputs hold the same sample.
   always_comb begin
      pop        = !fifo_empty && dout_ready;
      drop       = s3_v_q && fifo_full && !pop;
      overflow_d = overflow_q;
      if (gs) begin
         overflow_d = 1'b0;
      end
      // A drop wins over a simultaneous clear.
      if (drop) begin
         overflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_q      <= 1'b0;
         idx_q      <= '0;
         s1_v_q     <= 1'b0;
         s1_x_q     <= '0;
         s1_s_q     <= '0;
         s1_c_q     <= '0;
         s1_idx_q   <= '0;
         s2_v_q     <= 1'b0;
         s2_p_q     <= '0;
         s2_s_q     <= '0;
         s2_idx_q   <= '0;
         s3_v_q     <= 1'b0;
         s3_val_q   <= '0;
         s3_idx_q   <= '0;
         overflow_q <= 1'b0;
      end else begin
         run_q      <= run_d;
         idx_q      <= idx_d;
         s1_v_q     <= s1_v_d;
         s1_x_q     <= s1_x_d;
         s1_s_q     <= s1_s_d;
         s1_c_q     <= s1_c_d;
         s1_idx_q   <= s1_idx_d;
         s2_v_q     <= s2_v_d;
         s2_p_q     <= s2_p_d;
         s2_s_q     <= s2_s_d;
         s2_idx_q   <= s2_idx_d;
         s3_v_q     <= s3_v_d;
         s3_val_q   <= s3_val_d;
         s3_idx_q   <= s3_idx_d;
         overflow_q <= overflow_d;
      end
   end

   sync_fifo_fwft #(
      .WIDTH (FIFO_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (s3_v_q),
      .wr_data ({s3_idx_q, s3_val_q}),
      .rd_en   (dout_ready),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // Outputs are forced to zero while empty so reset and idle never expose
   // uninitialised FIFO storage.
   assign dout_v     = !fifo_empty;
   assign sample_out = fifo_empty ? '0 : $signed(fifo_rd_data[SAMPLE_W-1:0]);
   assign sample_idx = fifo_empty ? '0 : fifo_rd_data[FIFO_W-1:SAMPLE_W];
   assign last       = dout_v && (sample_idx == LAST_IDX);
   assign overflow   = overflow_q;

endmodule

// File: tb/tb_requant_descaler.sv
// tb_requant_descaler
//   Directed vector table, granule/overflow/reset sequences and a random
//   phase, all checked against a plain-arithmetic reference model.
module tb_requant_descaler;

   localparam int DEPTH = 8;
   localparam int SW    = 24;
   localparam int IW    = 10;
   localparam int W     = SW + IW;

   logic               clk = 1'b0;
   logic               rst_n;
   logic signed [15:0] x_in;
   logic [9:0]         x_base_in;
   logic               din_v;
   logic               granule_start;
   logic               dout_ready;
   logic [SW-1:0]      sample_out;
   logic [IW-1:0]      sample_idx;
   logic               last;
   logic               dout_v;
   logic               overflow;

   always #5 clk = ~clk;

   requant_descaler #(
      .FIFO_DEPTH (DEPTH),
      .SAMPLE_W   (SW)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .x_in          (x_in),
      .x_base_in     (x_base_in),
      .din_v         (din_v),
      .granule_start (granule_start),
      .dout_ready    (dout_ready),
      .sample_out    (sample_out),
      .sample_idx    (sample_idx),
      .last          (last),
      .dout_v        (dout_v),
      .overflow      (overflow)
   );

   int          n_checks = 0;
   int          n_errors = 0;
   logic [W-1:0] exp_q[$];
   int          gidx = 0;
   bit          mon_en = 0;
   bit          track = 0;
   int          cyc = 0;
   int          first_pop = 0;
   int          last_pop = 0;
   int          pop_cnt = 0;
   int          coef_tab[4] = '{32768, 27554, 23170, 19484};

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic signed [63:0] act,
                        input logic signed [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   // value = x * 2^(-base/4), fractional octave from the Q1.15 table,
   // rounded toward minus infinity, then clamped to 24-bit signed.
   function automatic int ref_sample(int x, int base);
      longint p, d, q;
      int s, k;
      s = base / 4;
      k = base % 4;
      if (s >= 32) return 0;
      p = longint'(x) * longint'(coef_tab[k]);
      d = longint'(1) << s;
      q = p / d;
      if ((q * d) != p && p < 0) q = q - 1;
      if (q > 8388607) q = 8388607;
      if (q < -8388608) q = -8388608;
      return int'(q);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drives one sample for one cycle and updates the bench's granule index.
   task automatic send(input int x, input int base, input bit gs, input bit expect_it);
      int idx;
      int r;
      din_v         = 1'b1;
      x_in          = 16'(x);
      x_base_in     = 10'(base);
      granule_start = gs;
      idx  = gs ? 0 : gidx;
      r    = ref_sample(x, base);
      if (expect_it) exp_q.push_back({IW'(idx), SW'(r)});
      gidx = (idx + 1) % 576;
      step();
      din_v         = 1'b0;
      granule_start = 1'b0;
   endtask

   task automatic drain(input int budget, input string name);
      for (int i = 0; i < budget; i++) begin
         if (exp_q.size() == 0) break;
         step();
      end
      repeat (6) step();
      check(name, exp_q.size(), 0);
   endtask

   function automatic int rand_x();
      logic [15:0] r;
      r = 16'($urandom_range(0, 65535));
      return int'($signed(r));
   endfunction

   function automatic int rand_base();
      if ($urandom_range(0, 7) == 0) return int'($urandom_range(0, 1023));
      return int'($urandom_range(0, 100));
   endfunction

   // Output monitor: scoreboard pops and stall stability.
   logic [W+1:0] prev_out;
   bit           prev_stall = 0;
   always @(negedge clk) begin
      logic [W-1:0] e;
      logic [SW-1:0] e_s;
      logic [IW-1:0] e_i;
      if (rst_n && mon_en) begin
         if (prev_stall) check("stall_hold", {sample_idx, sample_out, last, dout_v}, prev_out);
         if (dout_v && dout_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_pop: got idx %0d sample %0d expected nothing",
                        sample_idx, $signed(sample_out));
            end else begin
               e   = exp_q.pop_front();
               e_s = e[SW-1:0];
               e_i = e[W-1:SW];
               check("mon_sample", $signed(sample_out), $signed(e_s));
               check("mon_idx", sample_idx, e_i);
               check("mon_last", last, (e_i == 10'd575));
            end
            if (track) begin
               if (pop_cnt == 0) first_pop = cyc;
               last_pop = cyc;
               pop_cnt++;
            end
         end
         prev_stall = dout_v && !dout_ready;
         prev_out   = {sample_idx, sample_out, last, dout_v};
      end else begin
         prev_stall = 0;
      end
   end

   typedef struct {
      int x;
      int base;
      int exp;
   } vec_t;

   vec_t tv[12];

   initial begin
      tv[0]  = '{100,    28,  25600};
      tv[1]  = '{-100,   29,  -21527};
      tv[2]  = '{1000,   0,   8388607};
      tv[3]  = '{-1000,  0,   -8388608};
      tv[4]  = '{5,      200, 0};
      tv[5]  = '{7,      4,   114688};
      tv[6]  = '{-1,     43,  -20};
      tv[7]  = '{-7,     124, -1};
      tv[8]  = '{-7,     128, 0};
      tv[9]  = '{12345,  34,  1117318};
      tv[10] = '{32767,  3,   8388607};
      tv[11] = '{-32768, 508, 0};

      rst_n = 1'b1;
      din_v = 1'b0;
      x_in = '0;
      x_base_in = '0;
      granule_start = 1'b0;
      dout_ready = 1'b1;
      #2 rst_n = 1'b0;
      repeat (3) step();

      // Reset state
      check("rst_dout_v", dout_v, 0);
      check("rst_sample", sample_out, 0);
      check("rst_idx", sample_idx, 0);
      check("rst_last", last, 0);
      check("rst_overflow", overflow, 0);

      // Release: first edge must ignore din_v, second edge accepts it.
      mon_en = 1;
      gidx   = 0;
      rst_n  = 1'b1;
      din_v = 1'b1; x_in = 16'sd111; x_base_in = 10'd60;
      step();
      send(222, 60, 0, 1);
      drain(20, "release_first_accept");

      // Directed vectors with exact latency, one at a time.
      mon_en = 0;
      repeat (3) step();
      for (int i = 0; i < 12; i++) begin
         din_v = 1'b1;
         x_in = 16'(tv[i].x);
         x_base_in = 10'(tv[i].base);
         granule_start = (i == 0);
         step();
         din_v = 1'b0;
         granule_start = 1'b0;
         step();
         step();
         check($sformatf("vec%0d_early", i), dout_v, 0);
         step();
         check($sformatf("vec%0d_valid", i), dout_v, 1);
         check($sformatf("vec%0d_sample", i), $signed(sample_out), tv[i].exp);
         check($sformatf("vec%0d_idx", i), sample_idx, i);
         step();
      end
      gidx = 12;

      // Full granule back-to-back plus one wrap sample.
      mon_en = 1;
      track = 1;
      pop_cnt = 0;
      for (int i = 0; i < 577; i++) send(rand_x(), rand_base(), (i == 0), 1);
      drain(20, "granule_drain");
      track = 0;
      check("granule_pops", pop_cnt, 577);
      check("granule_no_bubble", last_pop - first_pop, 576);

      // Overflow: 20 samples into a stalled 8-deep FIFO.
      dout_ready = 1'b0;
      granule_start = 1'b1;
      step();
      granule_start = 1'b0;
      gidx = 0;
      for (int i = 0; i < 20; i++) send(rand_x(), rand_base(), 0, (i < DEPTH));
      repeat (5) step();
      check("ovf_set", overflow, 1);
      check("ovf_dout_v", dout_v, 1);
      check("ovf_stored", exp_q.size(), DEPTH);
      dout_ready = 1'b1;
      drain(30, "ovf_drain");
      check("ovf_sticky", overflow, 1);
      granule_start = 1'b1;
      step();
      granule_start = 1'b0;
      gidx = 0;
      check("ovf_clear", overflow, 0);

      // Random traffic with random backpressure, kept below FIFO capacity.
      for (int c = 0; c < 800; c++) begin
         bit gs;
         dout_ready = ($urandom_range(0, 3) != 0);
         gs = ($urandom_range(0, 49) == 0);
         if (exp_q.size() < DEPTH && $urandom_range(0, 1) == 1) begin
            send(rand_x(), rand_base(), gs, 1);
         end else begin
            granule_start = gs;
            if (gs) gidx = 0;
            step();
            granule_start = 1'b0;
         end
      end
      dout_ready = 1'b1;
      drain(40, "random_drain");
      check("random_no_overflow", overflow, 0);

      // Reset in the middle of a stalled stream.
      dout_ready = 1'b0;
      for (int i = 0; i < 6; i++) send(rand_x(), rand_base(), 0, 0);
      rst_n = 1'b0;
      #1;
      check("midrst_dout_v", dout_v, 0);
      check("midrst_sample", sample_out, 0);
      check("midrst_overflow", overflow, 0);
      exp_q.delete();
      gidx = 0;
      step();
      step();
      rst_n = 1'b1;
      step();
      dout_ready = 1'b1;
      for (int i = 0; i < 3; i++) send(rand_x(), rand_base(), 0, 1);
      drain(20, "midrst_restart");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
